// File: rtl/sll_op_initiator_if.sv
// Host command/response streams plus the op port toward the linked list core.
// The master modport is the initiator's view; slave is the host and core side.
interface sll_op_initiator_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] rsp_next_addr;
    logic                  rsp_fault;
    logic                  rsp_timeout;

    logic [2:0]            op;
    logic                  op_start;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  op_done;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ADDR_WIDTH-1:0] next_node_addr;
    logic                  fault;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, cmd_addr,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_next_addr, rsp_fault, rsp_timeout,
        input  rsp_ready,
        output op, op_start, data_in, addr_in,
        input  op_done, data_out, next_node_addr, fault
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, cmd_addr,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_next_addr, rsp_fault, rsp_timeout,
        output rsp_ready,
        input  op, op_start, data_in, addr_in,
        output op_done, data_out, next_node_addr, fault
    );
endinterface

// File: rtl/sll_op_initiator.sv
// Command-side initiator for the linked list core: one command in flight, a
// single-cycle op_start pulse, bounded wait for op_done, registered response.
module sll_op_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    sll_op_initiator_if.master bus,
    output logic               busy,
    output logic [7:0]         timeout_cnt
);
    localparam int              TW          = $clog2(TIMEOUT);
    localparam logic [2:0]      OP_RESERVED = 3'd7;
    localparam logic [TW-1:0]   TIMER_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic                  cmd_ready_q;
    logic                  busy_q;
    logic                  op_start_q;
    logic                  rsp_valid_q;
    logic                  rsp_fault_q;
    logic                  rsp_timeout_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [ADDR_WIDTH-1:0] rsp_next_q;
    logic [2:0]            op_q;
    logic [DATA_WIDTH-1:0] data_in_q;
    logic [ADDR_WIDTH-1:0] addr_in_q;
    logic [TW-1:0]         wait_timer;
    logic [TW-1:0]         timer_next;
    logic [7:0]            timeout_cnt_q;

    logic accept;
    logic reserved_hit;
    logic done_hit;
    logic timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In WAIT the timer is judged after this cycle's increment, so op_done
    // sampled on the same edge as the limit still wins.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        reserved_hit = 1'b0;
        done_hit     = 1'b0;
        timeout_hit  = 1'b0;
        timer_next   = wait_timer + 1'b1;
        case (state)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    accept = 1'b1;
                    if (bus.cmd_op == OP_RESERVED) begin
                        reserved_hit = 1'b1;
                        state_next   = RESP;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.op_done) begin
                    done_hit   = 1'b1;
                    state_next = RESP;
                end else if (timer_next == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and status flags are registered copies of the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            op_start_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            cmd_ready_q <= (state_next == IDLE);
            busy_q      <= (state_next != IDLE);
            op_start_q  <= (state_next == ISSUE);
            rsp_valid_q <= (state_next == RESP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= 3'd0;
            data_in_q <= '0;
            addr_in_q <= '0;
        end else if (accept) begin
            op_q      <= bus.cmd_op;
            data_in_q <= bus.cmd_data;
            addr_in_q <= bus.cmd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_timer <= '0;
        end else if (state == ISSUE) begin
            wait_timer <= '0;
        end else if (state == WAIT) begin
            wait_timer <= timer_next;
        end
    end

    // Response fields only change on entry to RESP, so they hold while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data_q    <= '0;
            rsp_next_q    <= '0;
            rsp_fault_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else if (reserved_hit) begin
            rsp_data_q    <= '0;
            rsp_next_q    <= '0;
            rsp_fault_q   <= 1'b1;
            rsp_timeout_q <= 1'b0;
        end else if (done_hit) begin
            rsp_data_q    <= bus.data_out;
            rsp_next_q    <= bus.next_node_addr;
            rsp_fault_q   <= bus.fault;
            rsp_timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            rsp_data_q    <= '0;
            rsp_next_q    <= '0;
            rsp_fault_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_cnt_q <= 8'd0;
        end else if (timeout_hit && (timeout_cnt_q != 8'hFF)) begin
            timeout_cnt_q <= timeout_cnt_q + 8'd1;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_next_addr = rsp_next_q;
    assign bus.rsp_fault     = rsp_fault_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.op            = op_q;
    assign bus.op_start      = op_start_q;
    assign bus.data_in       = data_in_q;
    assign bus.addr_in       = addr_in_q;
    assign busy              = busy_q;
    assign timeout_cnt       = timeout_cnt_q;
endmodule
